// File: rtl/sram_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_stream_reader_pkg
// Purpose  : Shared types, widths and SRAM control constants for the
//            frame-buffer SRAM reader (and its writer counterpart).
// Revision : 1.0 - initial release
// ============================================================================
package sram_stream_reader_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    // Active-low SRAM control levels for a read-only master
    localparam logic CE_ON       = 1'b0;
    localparam logic WE_READ     = 1'b1;
    localparam logic BYTE_EN_ALL = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } rd_state_t;

    // Word the frame-buffer writer stores at each address
    function automatic logic [SRAM_DATA_W-1:0] test_pattern(input logic [SRAM_ADDR_W-1:0] addr);
        return {addr[9:2], 8'h00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_rd_checker.sv
`default_nettype none
// ============================================================================
// Module   : sram_rd_checker
// Purpose  : Compares each captured SRAM word against the writer pattern and
//            keeps a sticky error flag plus a saturating mismatch count.
// Revision : 1.0 - initial release
// ============================================================================
module sram_rd_checker
    import sram_stream_reader_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              capture,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic              err,
    output logic [15:0]       err_cnt
);

    logic [DATA_W-1:0] w_expect;
    logic              w_mismatch;
    logic              r_err;
    logic [15:0]       r_err_cnt;

    assign w_expect   = DATA_W'(test_pattern(SRAM_ADDR_W'(addr)));
    assign w_mismatch = capture && (data != w_expect);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err     <= 1'b0;
            r_err_cnt <= 16'd0;
        end else if (clr) begin
            r_err     <= 1'b0;
            r_err_cnt <= 16'd0;
        end else if (w_mismatch) begin
            r_err <= 1'b1;
            if (r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign err     = r_err;
    assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: rtl/sram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : sram_stream_reader
// Purpose  : Sweeps an inclusive SRAM address range (wrapping at the top of
//            memory) and streams each word out over valid/ready.
//            Optional build macro SRAM_RD_CHECK_EN adds pattern checking.
// Revision : 1.0 - initial release
// ============================================================================
module sram_stream_reader
    import sram_stream_reader_pkg::*;
#(
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int DATA_W   = SRAM_DATA_W,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic              ce_n,
    output logic              we_n,
    output logic              ub_n,
    output logic              lb_n,
    output logic              oe_n,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready
`ifdef SRAM_RD_CHECK_EN
    ,
    output logic              err,
    output logic [15:0]       err_cnt
`endif
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC - 1);

    rd_state_t         r_state;
    rd_state_t         w_state_nxt;

    logic [ADDR_W-1:0] r_addr,      w_addr_nxt;
    logic [ADDR_W-1:0] r_last_addr, w_last_addr_nxt;
    logic [3:0]        r_wait_cnt,  w_wait_cnt_nxt;
    logic              r_oe_n,      w_oe_n_nxt;
    logic              r_m_valid,   w_m_valid_nxt;
    logic [DATA_W-1:0] r_m_data,    w_m_data_nxt;
    logic              r_m_last,    w_m_last_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_done,      w_done_nxt;
    logic              w_handshake;

    // The reader never drives the data bus
    assign sram_dq = {DATA_W{1'bz}};

    assign w_handshake = r_m_valid && m_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start) w_state_nxt = ADDR;
            ADDR: w_state_nxt = WAIT;
            WAIT: if (r_wait_cnt == 4'd0) w_state_nxt = OUT;
            OUT:  if (w_handshake) w_state_nxt = r_m_last ? IDLE : ADDR;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_addr_nxt      = r_addr;
        w_last_addr_nxt = r_last_addr;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_oe_n_nxt      = r_oe_n;
        w_m_valid_nxt   = r_m_valid;
        w_m_data_nxt    = r_m_data;
        w_m_last_nxt    = r_m_last;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_last_addr_nxt = last_addr;
                    w_addr_nxt      = base_addr;
                    w_oe_n_nxt      = 1'b0;
                    w_busy_nxt      = 1'b1;
                end
            end
            ADDR: begin
                w_wait_cnt_nxt = WAIT_INIT;
            end
            WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_m_data_nxt  = sram_dq;
                    w_m_valid_nxt = 1'b1;
                    w_m_last_nxt  = (r_addr == r_last_addr);
                    w_oe_n_nxt    = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
                end
            end
            OUT: begin
                if (w_handshake) begin
                    w_m_valid_nxt = 1'b0;
                    w_m_last_nxt  = 1'b0;
                    if (r_m_last) begin
                        w_busy_nxt = 1'b0;
                        w_done_nxt = 1'b1;
                    end else begin
                        // Natural modulo-2^ADDR_W wrap gives the top-to-zero rollover
                        w_addr_nxt = r_addr + ADDR_W'(1);
                        w_oe_n_nxt = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr      <= '0;
            r_last_addr <= '0;
            r_wait_cnt  <= 4'd0;
            r_oe_n      <= 1'b1;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_last    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_addr      <= w_addr_nxt;
            r_last_addr <= w_last_addr_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_oe_n      <= w_oe_n_nxt;
            r_m_valid   <= w_m_valid_nxt;
            r_m_data    <= w_m_data_nxt;
            r_m_last    <= w_m_last_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign sram_addr = r_addr;
    assign oe_n      = r_oe_n;
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_last    = r_m_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign ce_n      = CE_ON;
    assign we_n      = WE_READ;
    assign ub_n      = BYTE_EN_ALL;
    assign lb_n      = BYTE_EN_ALL;

`ifdef SRAM_RD_CHECK_EN
    logic w_accept;
    logic w_capture;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_capture = (r_state == WAIT) && (r_wait_cnt == 4'd0);

    sram_rd_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_checker (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_accept),
        .capture (w_capture),
        .addr    (r_addr),
        .data    (sram_dq),
        .err     (err),
        .err_cnt (err_cnt)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_stream_reader
// Purpose  : Self-checking bench for sram_stream_reader (WAIT_CYC = 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_stream_reader;

    localparam int WC = 3;

    logic        clk;
    logic        rst;
    logic        start;
    logic [19:0] base_addr;
    logic [19:0] last_addr;
    logic        busy;
    logic        done;
    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        ce_n, we_n, ub_n, lb_n, oe_n;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_last;
    logic        m_ready;
`ifdef SRAM_RD_CHECK_EN
    logic        err;
    logic [15:0] err_cnt;
`endif

    bit          data_mode;
    bit          corrupt_en;
    logic [15:0] salt;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [19:0] base;
        logic [19:0] last;
        int          stall_beat;
        int          stall_len;
        bit          rdy_rand;
        bit          start_on_last;
        int          abort_at;
        bit          dmode;
        bit          corrupt;
        int          exp_words;
    } vec_t;

    vec_t vecs[9];

    sram_stream_reader #(
        .ADDR_W   (20),
        .DATA_W   (16),
        .WAIT_CYC (WC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .last_addr (last_addr),
        .busy      (busy),
        .done      (done),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq),
        .ce_n      (ce_n),
        .we_n      (we_n),
        .ub_n      (ub_n),
        .lb_n      (lb_n),
        .oe_n      (oe_n),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready)
`ifdef SRAM_RD_CHECK_EN
        ,
        .err       (err),
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: writer pattern, or a scrambled word, with optional corruption at 5
    function automatic logic [15:0] mem_word(input logic [19:0] a, input bit dm,
                                             input logic [15:0] s, input bit cor);
        logic [19:0] prod;
        if (cor && a == 20'h00005) return 16'hBEEF;
        if (!dm) return {a[9:2], 8'h00};
        prod = a * 20'h09E37;
        return prod[15:0] ^ s ^ {12'h000, a[19:16]};
    endfunction

    function automatic logic [15:0] writer_pattern(input logic [19:0] a);
        return {a[9:2], 8'h00};
    endfunction

    assign sram_dq = mem_word(sram_addr, data_mode, salt, corrupt_en);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  32'(sram_addr), 32'h0);
        check({tag, "_oe_n"},  32'(oe_n),      32'h1);
        check({tag, "_valid"}, 32'(m_valid),   32'h0);
        check({tag, "_data"},  32'(m_data),    32'h0);
        check({tag, "_last"},  32'(m_last),    32'h0);
        check({tag, "_busy"},  32'(busy),      32'h0);
        check({tag, "_done"},  32'(done),      32'h0);
`ifdef SRAM_RD_CHECK_EN
        check({tag, "_err"},     32'(err),     32'h0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'h0);
`endif
    endtask

    task automatic run_sweep(input vec_t v);
        logic [19:0] span;
        logic [19:0] a;
        logic [15:0] w;
        int  n, k, cyc, stall_cnt, budget, err_exp;
        bit  fin, seen, hold, aborted, timed;

        span = v.last - v.base;
        n    = int'(span) + 1;
        timed = !v.rdy_rand && v.stall_len == 0 && v.abort_at < 0;

        @(negedge clk);
        data_mode  = v.dmode;
        corrupt_en = v.corrupt;
        salt       = 16'($urandom);
        start      = 1'b1;
        base_addr  = v.base;
        last_addr  = v.last;
        m_ready    = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        base_addr = 20'($urandom);
        last_addr = 20'($urandom);
        check("start_busy", 32'(busy), 32'h1);
        check("start_addr", 32'(sram_addr), 32'(v.base));
        check("start_oe_n", 32'(oe_n), 32'h0);
`ifdef SRAM_RD_CHECK_EN
        check("start_err_clr", 32'(err), 32'h0);
        check("start_cnt_clr", 32'(err_cnt), 32'h0);
`endif

        k = 0; cyc = 0; stall_cnt = 0; err_exp = 0;
        fin = 0; seen = 0; hold = 0; aborted = 0;
        budget = n * (WC + 4 + v.stall_len) * (v.rdy_rand ? 4 : 1) + 40;

        while (!fin && cyc < budget) begin
            if (hold) check("valid_held", 32'(m_valid), 32'h1);
            hold = 0;
            if (done) begin
                fin = 1;
            end else if (m_valid && v.abort_at >= 0 && k == v.abort_at) begin
                rst = 1'b0;
                #1;
                check_reset_outputs("abort");
                aborted = 1;
                fin = 1;
            end else if (m_valid) begin
                a = v.base + 20'(k);
                w = mem_word(a, v.dmode, salt, v.corrupt);
                if (!seen) begin
                    seen = 1;
                    if (w != writer_pattern(a)) err_exp++;
                    if (timed) check("beat_timing", 32'(cyc), 32'(1 + WC + k * (WC + 2)));
                end
                check("beat_addr", 32'(sram_addr), 32'(a));
                check("beat_data", 32'(m_data), 32'(w));
                check("beat_last", 32'(m_last), 32'(k == n - 1));
                check("out_oe_n", 32'(oe_n), 32'h1);
                if (k == v.stall_beat && stall_cnt < v.stall_len) begin
                    m_ready = 1'b0;
                    stall_cnt++;
                end else if (v.rdy_rand) begin
                    m_ready = 1'($urandom_range(0, 1));
                end else begin
                    m_ready = 1'b1;
                end
                if (m_ready) begin
                    start = (k == n - 1) ? v.start_on_last : 1'($urandom_range(0, 1));
                    k++;
                    seen = 0;
                end else begin
                    start = 1'($urandom_range(0, 1));
                    hold = 1;
                end
            end else begin
                check("rd_busy", 32'(busy), 32'h1);
                check("rd_oe_n", 32'(oe_n), 32'h0);
                m_ready = 1'($urandom_range(0, 1));
                start   = 1'($urandom_range(0, 1));
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;

        if (!fin) check("sweep_timeout", 32'h0, 32'h1);

        if (aborted) begin
            @(negedge clk);
            rst = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("post_abort_done", 32'(done), 32'h0);
                check("post_abort_busy", 32'(busy), 32'h0);
            end
        end else if (fin) begin
            check("beat_count", 32'(k), 32'(v.exp_words));
            check("done_pulse", 32'(done), 32'h1);
            check("done_busy", 32'(busy), 32'h0);
            check("done_valid", 32'(m_valid), 32'h0);
            check("done_oe_n", 32'(oe_n), 32'h1);
`ifdef SRAM_RD_CHECK_EN
            check("sweep_err", 32'(err), 32'(err_exp != 0));
            check("sweep_err_cnt", 32'(err_cnt), 32'(err_exp));
`endif
            @(negedge clk);
            check("done_once", 32'(done), 32'h0);
            check("idle_busy", 32'(busy), 32'h0);
        end
    endtask

    initial begin
        //            base       last       sbeat slen rnd sol abort dm cor words
        vecs[0] = '{20'h00010, 20'h00010, -1, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1};
        vecs[1] = '{20'h00000, 20'h00003,  1, 5, 1'b0, 1'b0, -1, 1'b1, 1'b0, 4};
        vecs[2] = '{20'hFFFFE, 20'h00001, -1, 0, 1'b0, 1'b0, -1, 1'b1, 1'b0, 4};
        vecs[3] = '{20'h00100, 20'h00104, -1, 0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 5};
        vecs[4] = '{20'h00000, 20'h00007, -1, 0, 1'b0, 1'b0,  1, 1'b0, 1'b0, 8};
        vecs[5] = '{20'h00000, 20'h00007, -1, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 8};
        vecs[6] = '{20'h00000, 20'h00007, -1, 0, 1'b0, 1'b0, -1, 1'b0, 1'b1, 8};
        vecs[7] = '{20'h00020, 20'h00023, -1, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 4};
        vecs[8] = '{20'hABCDE, 20'hABCE9,  3, 4, 1'b1, 1'b0, -1, 1'b1, 1'b0, 12};

        rst = 1'b0; start = 1'b0; base_addr = '0; last_addr = '0; m_ready = 1'b0;
        data_mode = 1'b0; corrupt_en = 1'b0; salt = 16'h0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        check("const_ce_n", 32'(ce_n), 32'h0);
        check("const_we_n", 32'(we_n), 32'h1);
        check("const_ub_n", 32'(ub_n), 32'h0);
        check("const_lb_n", 32'(lb_n), 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_busy", 32'(busy), 32'h0);

        for (int i = 0; i < 9; i++) begin
            run_sweep(vecs[i]);
        end

        for (int i = 0; i < 6; i++) begin
            vec_t rv;
            logic [19:0] sp;
            sp = 20'($urandom_range(0, 12));
            rv.base          = 20'($urandom);
            rv.last          = rv.base + sp;
            rv.stall_beat    = int'($urandom_range(0, 12));
            rv.stall_len     = int'($urandom_range(0, 6));
            rv.rdy_rand      = 1'b1;
            rv.start_on_last = 1'($urandom_range(0, 1));
            rv.abort_at      = -1;
            rv.dmode         = 1'($urandom_range(0, 1));
            rv.corrupt       = 1'($urandom_range(0, 1));
            rv.exp_words     = int'(sp) + 1;
            run_sweep(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
